// File: rtl/calc_pkg.sv
// calc_pkg: definitions shared by the keypad front end and the calculator FSM.
//   - ASCII constants for the operator/control keys
//   - kp_state_e: keypad scanner state encoding
//   - key_ascii(row, col): 4x4 keymap; the r3c3 position is unmapped and returns 8'h00
//   - key_is_digit(ch): true for ASCII '0'..'9'
package calc_pkg;

  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_MUL   = 8'h2A;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_CLR   = 8'h43;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_NONE  = 8'h00;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } kp_state_e;

  function automatic logic [7:0] key_ascii(input logic [1:0] row, input logic [1:0] col);
    logic [7:0] ch;
    case ({row, col})
      4'h0:    ch = 8'h31;
      4'h1:    ch = 8'h32;
      4'h2:    ch = 8'h33;
      4'h3:    ch = CH_PLUS;
      4'h4:    ch = 8'h34;
      4'h5:    ch = 8'h35;
      4'h6:    ch = 8'h36;
      4'h7:    ch = CH_MINUS;
      4'h8:    ch = 8'h37;
      4'h9:    ch = 8'h38;
      4'hA:    ch = 8'h39;
      4'hB:    ch = CH_MUL;
      4'hC:    ch = CH_CLR;
      4'hD:    ch = 8'h30;
      4'hE:    ch = CH_EQ;
      default: ch = CH_NONE;
    endcase
    return ch;
  endfunction

  function automatic logic key_is_digit(input logic [7:0] ch);
    return (ch >= 8'h30) && (ch <= 8'h39);
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: WIDTH-bit two-flop synchroniser for asynchronous inputs.
// Both stages reset to all-ones so an idle (pulled-up) keypad is seen during reset.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   i_d    in  WIDTH asynchronous input
//   o_q    out WIDTH synchronised output
module keypad_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= {WIDTH{1'b1}};
      r_sync <= {WIDTH{1'b1}};
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce and ASCII strobes.
// Walks an active-low column drive, samples the synchronised rows at the end of
// each dwell, debounces a single-key press, emits a one-cycle btn_valid with
// btn_char, and keeps key_held high until the release is debounced.
// Optional build macro: KEYPAD_AUTOREPEAT_EN (auto-repeat of held digit keys).
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   row_in     in  4  keypad rows, active-low, asynchronous
//   col_out    out 4  column drive, active-low one-hot
//   btn_valid  out 1  one-cycle key-accepted strobe
//   btn_char   out 8  ASCII of the last accepted key
//   key_held   out 1  high from acceptance until release is debounced
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DWELL    = 1000,
  parameter int DEBOUNCE_CNT  = 20000,
  parameter int REPEAT_DELAY  = 5000000,
  parameter int REPEAT_PERIOD = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       btn_valid,
  output logic [7:0] btn_char,
  output logic       key_held
);

  localparam int DW_W = $clog2(SCAN_DWELL);
  localparam int DB_W = $clog2(DEBOUNCE_CNT);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(SCAN_DWELL - 1);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CNT - 1);

  logic [3:0] w_rs;

  keypad_sync #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (row_in),
    .o_q   (w_rs)
  );

  kp_state_e       r_state, w_state;
  logic [1:0]      r_col, w_col;
  logic [3:0]      r_col_out, w_col_out;
  logic [DW_W-1:0] r_dwell, w_dwell;
  logic [DB_W-1:0] r_cnt, w_cnt;
  logic [1:0]      r_row, w_row;
  logic [3:0]      r_pat, w_pat;
  logic            r_valid, w_valid;
  logic [7:0]      r_char, w_char;
  logic            r_held, w_held;

  logic [3:0] w_low;
  logic       w_one_low;
  logic [1:0] w_row_idx;
  logic [7:0] w_key;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);
  logic [REP_W-1:0] r_rep, w_rep;
  logic             r_rep_armed, w_rep_armed;
`endif

  // Row decode: a single low row is a candidate key; multiple lows are ghosts.
  always_comb begin
    w_low     = ~w_rs;
    w_one_low = (w_low != 4'b0000) && ((w_low & (w_low - 4'b0001)) == 4'b0000);
    case (w_low)
      4'b0001: w_row_idx = 2'd0;
      4'b0010: w_row_idx = 2'd1;
      4'b0100: w_row_idx = 2'd2;
      4'b1000: w_row_idx = 2'd3;
      default: w_row_idx = 2'd0;
    endcase
    w_key = key_ascii(r_row, r_col);
  end

  // Next-state and output logic for SCAN / DEBOUNCE / HELD.
  always_comb begin
    w_state = r_state;
    w_col   = r_col;
    w_dwell = r_dwell;
    w_cnt   = r_cnt;
    w_row   = r_row;
    w_pat   = r_pat;
    w_valid = 1'b0;
    w_char  = r_char;
    w_held  = r_held;
`ifdef KEYPAD_AUTOREPEAT_EN
    w_rep       = {REP_W{1'b0}};
    w_rep_armed = 1'b0;
`endif
    case (r_state)
      ST_SCAN: begin
        if (r_dwell == DWELL_LAST) begin
          w_dwell = {DW_W{1'b0}};
          if (w_one_low) begin
            w_row   = w_row_idx;
            w_pat   = w_rs;
            w_cnt   = {DB_W{1'b0}};
            w_state = ST_DEBOUNCE;
          end else begin
            w_col = r_col + 2'd1;
          end
        end else begin
          w_dwell = r_dwell + DW_W'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (w_rs == r_pat) begin
          if (r_cnt == DB_LAST) begin
            w_cnt   = {DB_W{1'b0}};
            w_held  = 1'b1;
            w_state = ST_HELD;
            // The unmapped key is tracked but never strobes.
            if (w_key != CH_NONE) begin
              w_valid = 1'b1;
              w_char  = w_key;
            end else begin
              w_valid = 1'b0;
            end
          end else begin
            w_cnt = r_cnt + DB_W'(1);
          end
        end else begin
          w_cnt   = {DB_W{1'b0}};
          w_dwell = {DW_W{1'b0}};
          w_col   = r_col + 2'd1;
          w_state = ST_SCAN;
        end
      end
      ST_HELD: begin
        // Only a fully idle row set counts toward release; column stays frozen.
        if (w_rs == 4'b1111) begin
          if (r_cnt == DB_LAST) begin
            w_cnt   = {DB_W{1'b0}};
            w_dwell = {DW_W{1'b0}};
            w_held  = 1'b0;
            w_state = ST_SCAN;
          end else begin
            w_cnt = r_cnt + DB_W'(1);
          end
        end else begin
          w_cnt = {DB_W{1'b0}};
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        // Repeat timer runs while the latched key's row is still low.
        if (!w_rs[r_row]) begin
          if (r_rep == (r_rep_armed ? REP_NEXT : REP_FIRST)) begin
            w_rep       = {REP_W{1'b0}};
            w_rep_armed = 1'b1;
            w_valid     = key_is_digit(w_key);
          end else begin
            w_rep       = r_rep + REP_W'(1);
            w_rep_armed = r_rep_armed;
          end
        end else begin
          w_rep       = {REP_W{1'b0}};
          w_rep_armed = 1'b0;
        end
`endif
      end
      default: begin
        w_state = ST_SCAN;
        w_col   = 2'd0;
        w_dwell = {DW_W{1'b0}};
        w_cnt   = {DB_W{1'b0}};
        w_held  = 1'b0;
      end
    endcase
    w_col_out = ~(4'b0001 << w_col);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_SCAN;
      r_col     <= 2'd0;
      r_col_out <= 4'b1110;
      r_dwell   <= {DW_W{1'b0}};
      r_cnt     <= {DB_W{1'b0}};
      r_row     <= 2'd0;
      r_pat     <= 4'b1111;
      r_valid   <= 1'b0;
      r_char    <= CH_SPACE;
      r_held    <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_rep       <= {REP_W{1'b0}};
      r_rep_armed <= 1'b0;
`endif
    end else begin
      r_state   <= w_state;
      r_col     <= w_col;
      r_col_out <= w_col_out;
      r_dwell   <= w_dwell;
      r_cnt     <= w_cnt;
      r_row     <= w_row;
      r_pat     <= w_pat;
      r_valid   <= w_valid;
      r_char    <= w_char;
      r_held    <= w_held;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_rep       <= w_rep;
      r_rep_armed <= w_rep_armed;
`endif
    end
  end

  assign col_out   = r_col_out;
  assign btn_valid = r_valid;
  assign btn_char  = r_char;
  assign key_held  = r_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner.
// A keypad matrix model turns a pressed[row][col] array plus col_out into row_in.
// Expected characters come from a keymap string; timing expectations come from
// the sync depth, dwell and debounce lengths. Honours KEYPAD_AUTOREPEAT_EN.
module tb_keypad_scanner;

  localparam int SD  = 4;
  localparam int DC  = 8;
  localparam int RD  = 50;
  localparam int RP  = 20;
  localparam int LAT = 2 + 4 * SD + DC + 1;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       btn_valid;
  logic [7:0] btn_char;
  logic       key_held;

  logic [3:0] pressed [4] = '{default: 4'b0000};
  string      keymap = "123+456-789*C0=";

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  int consec = 0;
  int cyc = 0;
  logic prev_valid = 1'b0;
  int strobe_cyc [$];

  keypad_scanner #(
    .SCAN_DWELL    (SD),
    .DEBOUNCE_CNT  (DC),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_in    (row_in),
    .col_out   (col_out),
    .btn_valid (btn_valid),
    .btn_char  (btn_char),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a row reads low if any pressed key in it sits on a driven column.
  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !col_out[c]) row_in[r] = 1'b0;
  end

  // Strobe monitor sampled on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    prev_valid <= btn_valid;
    if (btn_valid) begin
      strobes <= strobes + 1;
      strobe_cyc.push_back(cyc);
      if (prev_valid) consec <= consec + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    checks++; if (col_out !== 4'b1110) begin errors++; $display("FAIL reset_col got %b exp 1110", col_out); end
    checks++; if (btn_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", btn_valid); end
    checks++; if (btn_char !== 8'h20) begin errors++; $display("FAIL reset_char got %h exp 20", btn_char); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held got %b exp 0", key_held); end
    rst_n = 1'b1;
    tick(SD - 1);
    checks++; if (col_out !== 4'b1110) begin errors++; $display("FAIL dwell_c0 got %b exp 1110", col_out); end
    tick(1);
    checks++; if (col_out !== 4'b1101) begin errors++; $display("FAIL dwell_c1 got %b exp 1101", col_out); end
  endtask

  task automatic test_clean_press();
    int k = 0;
    bit found = 1'b0;
    int s0 = strobes;
    pressed[1][2] = 1'b1;
    while (!found && k < LAT + 4) begin tick(1); k++; if (btn_valid) found = 1'b1; end
    checks++; if (!found || k > LAT) begin errors++; $display("FAIL six_latency found %0d cycles %0d limit %0d", found, k, LAT); end
    checks++; if (btn_char !== 8'h36) begin errors++; $display("FAIL six_char got %h exp 36", btn_char); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL six_held got %b exp 1", key_held); end
    tick(3 * DC);
    checks++; if (strobes - s0 != 1) begin errors++; $display("FAIL six_count got %0d exp 1", strobes - s0); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL six_held_late got %b exp 1", key_held); end
    pressed[1][2] = 1'b0;
    tick(2 + DC - 1);
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL six_rel_early got %b exp 1", key_held); end
    tick(1);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL six_rel got %b exp 0", key_held); end
    tick(2);
    checks++; if (strobes - s0 != 1) begin errors++; $display("FAIL six_count_end got %0d exp 1", strobes - s0); end
  endtask

  task automatic test_bounce();
    int k = 0;
    bit found = 1'b0;
    int s0 = strobes;
    for (int i = 0; i < 10; i++) begin
      pressed[0][3] = ((i % 2) == 0);
      tick(3);
    end
    tick(2);
    checks++; if (strobes != s0) begin errors++; $display("FAIL bounce_quiet got %0d exp 0", strobes - s0); end
    pressed[0][3] = 1'b1;
    while (!found && k < LAT + 4) begin tick(1); k++; if (btn_valid) found = 1'b1; end
    checks++; if (!found || k > LAT) begin errors++; $display("FAIL bounce_latency found %0d cycles %0d", found, k); end
    checks++; if (btn_char !== 8'h2B) begin errors++; $display("FAIL bounce_char got %h exp 2b", btn_char); end
    tick(10);
    pressed[0][3] = 1'b0;
    tick(2 + DC + 2);
    checks++; if (strobes - s0 != 1) begin errors++; $display("FAIL bounce_count got %0d exp 1", strobes - s0); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL bounce_rel got %b exp 0", key_held); end
  endtask

  // Two keys on the same column drive two rows low: rejected as multi-key.
  task automatic test_multi_key();
    int k = 0;
    bit found = 1'b0;
    int s0 = strobes;
    pressed[1][0] = 1'b1;
    pressed[2][0] = 1'b1;
    tick(60);
    checks++; if (strobes != s0) begin errors++; $display("FAIL multi_quiet got %0d exp 0", strobes - s0); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL multi_held got %b exp 0", key_held); end
    pressed[1][0] = 1'b0;
    while (!found && k < LAT + 4) begin tick(1); k++; if (btn_valid) found = 1'b1; end
    checks++; if (!found || k > LAT) begin errors++; $display("FAIL multi_latency found %0d cycles %0d", found, k); end
    checks++; if (btn_char !== 8'h37) begin errors++; $display("FAIL multi_char got %h exp 37", btn_char); end
    pressed[2][0] = 1'b0;
    tick(2 + DC + 2);
    checks++; if (strobes - s0 != 1) begin errors++; $display("FAIL multi_count got %0d exp 1", strobes - s0); end
  endtask

  task automatic test_unmapped();
    int k = 0;
    bit found = 1'b0;
    int s0 = strobes;
    pressed[3][3] = 1'b1;
    while (!found && k < LAT + 4) begin tick(1); k++; if (key_held) found = 1'b1; end
    checks++; if (!found || k > LAT) begin errors++; $display("FAIL unmap_held found %0d cycles %0d", found, k); end
    tick(20);
    checks++; if (strobes != s0) begin errors++; $display("FAIL unmap_quiet got %0d exp 0", strobes - s0); end
    pressed[3][3] = 1'b0;
    tick(2 + DC + 2);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL unmap_rel got %b exp 0", key_held); end
    pressed[3][0] = 1'b1;
    k = 0; found = 1'b0;
    while (!found && k < LAT + 4) begin tick(1); k++; if (btn_valid) found = 1'b1; end
    checks++; if (!found || btn_char !== 8'h43) begin errors++; $display("FAIL clr_char found %0d got %h exp 43", found, btn_char); end
    pressed[3][0] = 1'b0;
    tick(2 + DC + 2);
    checks++; if (strobes - s0 != 1) begin errors++; $display("FAIL clr_count got %0d exp 1", strobes - s0); end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    bit found = 1'b0;
    int s0;
    while (col_out !== 4'b1110 && k < 20) begin tick(1); k++; end
    pressed[2][2] = 1'b1;
    k = 0;
    while (col_out !== 4'b1011 && k < 20) begin tick(1); k++; end
    checks++; if (col_out !== 4'b1011) begin errors++; $display("FAIL rmid_col got %b exp 1011", col_out); end
    s0 = strobes;
    // Sample at dwell end (+SD), then debounce count 5.
    tick(SD + 5);
    rst_n = 1'b0;
    #1;
    checks++; if (col_out !== 4'b1110) begin errors++; $display("FAIL rmid_col_rst got %b exp 1110", col_out); end
    checks++; if (btn_char !== 8'h20 || btn_valid !== 1'b0 || key_held !== 1'b0) begin
      errors++; $display("FAIL rmid_outs char %h valid %b held %b exp 20 0 0", btn_char, btn_valid, key_held);
    end
    tick(3);
    checks++; if (strobes != s0) begin errors++; $display("FAIL rmid_quiet got %0d exp 0", strobes - s0); end
    rst_n = 1'b1;
    k = 0;
    while (!found && k < LAT + 4) begin tick(1); k++; if (btn_valid) found = 1'b1; end
    checks++; if (!found || k > LAT || btn_char !== 8'h39) begin
      errors++; $display("FAIL rmid_nine found %0d cycles %0d got %h exp 39", found, k, btn_char);
    end
    pressed[2][2] = 1'b0;
    tick(2 + DC + 2);
    checks++; if (strobes - s0 != 1) begin errors++; $display("FAIL rmid_count got %0d exp 1", strobes - s0); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      int idx, r, c, nb, k, s0, exp_n;
      bit found;
      logic [7:0] ch;
      idx = int'($urandom_range(0, 15));
      r = idx / 4;
      c = idx % 4;
      ch = (idx == 15) ? 8'h00 : keymap.getc(idx);
      exp_n = (idx == 15) ? 0 : 1;
      s0 = strobes;
      nb = int'($urandom_range(0, 3));
      for (int j = 0; j < nb; j++) begin
        pressed[r][c] = 1'b1;
        tick(int'($urandom_range(1, 3)));
        pressed[r][c] = 1'b0;
        tick(int'($urandom_range(1, 3)));
      end
      pressed[r][c] = 1'b1;
      k = 0; found = 1'b0;
      while (!found && k < LAT + 4) begin tick(1); k++; if (key_held) found = 1'b1; end
      checks++; if (!found || k > LAT) begin errors++; $display("FAIL rnd_latency key %0d found %0d cycles %0d", idx, found, k); end
      checks++; if (btn_valid !== (exp_n == 1)) begin errors++; $display("FAIL rnd_valid key %0d got %b exp %0d", idx, btn_valid, exp_n); end
      if (exp_n == 1) begin
        checks++; if (btn_char !== ch) begin errors++; $display("FAIL rnd_char key %0d got %h exp %h", idx, btn_char, ch); end
      end
      tick(int'($urandom_range(10, 40)));
      pressed[r][c] = 1'b0;
      tick(2 + DC - 1);
      checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL rnd_rel_early key %0d got %b exp 1", idx, key_held); end
      tick(1);
      checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL rnd_rel key %0d got %b exp 0", idx, key_held); end
      tick(2);
      checks++; if (strobes - s0 != exp_n) begin errors++; $display("FAIL rnd_count key %0d got %0d exp %0d", idx, strobes - s0, exp_n); end
    end
  endtask

  // Hold a key 120 cycles past its first strobe; digits repeat when enabled.
  task automatic test_long_hold(input int r, input int c, input logic [7:0] ch, input bit digit);
    int k = 0;
    bit found = 1'b0;
    int n0 = strobe_cyc.size();
    int exp_q [$];
    pressed[r][c] = 1'b1;
    while (!found && k < LAT + 4) begin tick(1); k++; if (btn_valid) found = 1'b1; end
    checks++; if (!found || btn_char !== ch) begin errors++; $display("FAIL hold_first found %0d got %h exp %h", found, btn_char, ch); end
    tick(120);
    pressed[r][c] = 1'b0;
    tick(2 + DC + 2);
    exp_q.push_back(0);
    if (REPEAT_ON && digit)
      for (int t = RD; t <= 120; t += RP) exp_q.push_back(t);
    checks++;
    if (strobe_cyc.size() - n0 != exp_q.size()) begin
      errors++; $display("FAIL hold_count char %h got %0d exp %0d", ch, strobe_cyc.size() - n0, exp_q.size());
    end else begin
      for (int i = 1; i < exp_q.size(); i++) begin
        checks++;
        if (strobe_cyc[n0 + i] - strobe_cyc[n0] != exp_q[i]) begin
          errors++; $display("FAIL hold_time idx %0d got %0d exp %0d", i, strobe_cyc[n0 + i] - strobe_cyc[n0], exp_q[i]);
        end
      end
    end
    checks++; if (btn_char !== ch) begin errors++; $display("FAIL hold_char got %h exp %h", btn_char, ch); end
  endtask

  task automatic test_strobe_width();
    checks++; if (consec != 0) begin errors++; $display("FAIL strobe_width got %0d exp 0", consec); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi_key();
    test_unmapped();
    test_reset_mid();
    test_random();
    test_long_hold(1, 1, 8'h35, 1'b1);
    test_long_hold(0, 3, 8'h2B, 1'b0);
    test_strobe_width();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
